// File: rtl/lcd_param_writer_if.sv
// Host-side byte channel of the LCD writer: iData/iRS/iValid from the host,
// oReady back from the controller. master = host, slave = controller.
interface lcd_param_writer_if;
   logic [7:0] iData;
   logic       iRS;
   logic       iValid;
   logic       oReady;

   modport master (
      output iData,
      output iRS,
      output iValid,
      input  oReady
   );

   modport slave (
      input  iData,
      input  iRS,
      input  iValid,
      output oReady
   );
endinterface

// File: rtl/lcd_param_writer.sv
// HD44780 4-bit LCD controller: power-on nibble init, config bytes, then
// host bytes over host (iData, iRS, iValid, oReady).
// Ports: Clock, Reset (sync, high), host, oInitDone, LCD_E/RS/RW, SF_DATA.
module lcd_param_writer #(
   parameter int T_POWERON = 750000,
   parameter int T_INIT1   = 205000,
   parameter int T_INIT2   = 5000,
   parameter int T_INIT3   = 2000,
   parameter int T_SETUP   = 2,
   parameter int T_PULSE   = 12,
   parameter int T_NIBGAP  = 50,
   parameter int T_CMD     = 2000,
   parameter int T_CLEAR   = 82000,
   parameter int CNT_W     = 20
) (
   input  logic                Clock,
   input  logic                Reset,
   lcd_param_writer_if.slave   host,
   output logic                oInitDone,
   output logic                LCD_E,
   output logic                LCD_RS,
   output logic                LCD_RW,
   output logic [3:0]          SF_DATA
);

   // Terminal counts: a state lasting N cycles leaves when cnt == N-1.
   localparam logic [CNT_W-1:0] L_PWR = CNT_W'(T_POWERON - 1);
   localparam logic [CNT_W-1:0] L_I1  = CNT_W'(T_INIT1 - 1);
   localparam logic [CNT_W-1:0] L_I2  = CNT_W'(T_INIT2 - 1);
   localparam logic [CNT_W-1:0] L_I3  = CNT_W'(T_INIT3 - 1);
   localparam logic [CNT_W-1:0] L_SU  = CNT_W'(T_SETUP - 1);
   localparam logic [CNT_W-1:0] L_PU  = CNT_W'(T_PULSE - 1);
   localparam logic [CNT_W-1:0] L_GAP = CNT_W'(T_NIBGAP - 1);
   localparam logic [CNT_W-1:0] L_CMD = CNT_W'(T_CMD - 1);
   localparam logic [CNT_W-1:0] L_CLR = CNT_W'(T_CLEAR - 1);

   typedef enum logic [3:0] {
      S_PWR, S_NSETUP, S_NPULSE, S_NWAIT,
      S_SETUP_H, S_PULSE_H, S_GAP,
      S_SETUP_L, S_PULSE_L, S_BWAIT, S_IDLE
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_step;
   logic [7:0]       r_byte;
   logic             r_rs;
   logic             r_ready;

   logic [CNT_W-1:0] w_lim;
   logic             w_done;
   logic             w_clr;
   logic [1:0]       w_step_nx;
   logic [7:0]       w_cfg_nx;
   logic [7:0]       w_cfg0;

   function automatic logic [7:0] cfg_byte(input logic [1:0] s);
      case (s)
         2'd0:    return 8'h28;
         2'd1:    return 8'h06;
         2'd2:    return 8'h0C;
         default: return 8'h01;
      endcase
   endfunction

   assign host.oReady = r_ready;
   assign LCD_RW      = 1'b0;

   // Clear/home commands need the long post-byte wait.
   assign w_clr     = !r_rs && (r_byte[7:2] == 6'd0) && (r_byte[1:0] != 2'd0);
   assign w_step_nx = r_step + 2'd1;
   assign w_cfg_nx  = cfg_byte(w_step_nx);
   assign w_cfg0    = cfg_byte(2'd0);

   always_comb begin
      w_lim = '0;
      case (r_state)
         S_PWR:     w_lim = L_PWR;
         S_NSETUP:  w_lim = L_SU;
         S_NPULSE:  w_lim = L_PU;
         S_NWAIT: begin
            case (r_step)
               2'd0:    w_lim = L_I1;
               2'd1:    w_lim = L_I2;
               default: w_lim = L_I3;
            endcase
         end
         S_SETUP_H: w_lim = L_SU;
         S_PULSE_H: w_lim = L_PU;
         S_GAP:     w_lim = L_GAP;
         S_SETUP_L: w_lim = L_SU;
         S_PULSE_L: w_lim = L_PU;
         S_BWAIT:   w_lim = w_clr ? L_CLR : L_CMD;
         default:   w_lim = '0;
      endcase
   end

   // IDLE has limit 0, so the counter simply sits at 0 there.
   assign w_done = (r_cnt == w_lim);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state   <= S_PWR;
         r_cnt     <= '0;
         r_step    <= '0;
         r_byte    <= '0;
         r_rs      <= 1'b0;
         r_ready   <= 1'b0;
         oInitDone <= 1'b0;
         LCD_E     <= 1'b0;
         LCD_RS    <= 1'b0;
         SF_DATA   <= 4'h0;
      end else begin
         r_cnt <= w_done ? '0 : r_cnt + 1'b1;
         case (r_state)
            S_PWR: if (w_done) begin
               r_state <= S_NSETUP;
               SF_DATA <= 4'h3;
            end
            S_NSETUP: if (w_done) begin
               r_state <= S_NPULSE;
               LCD_E   <= 1'b1;
            end
            S_NPULSE: if (w_done) begin
               r_state <= S_NWAIT;
               LCD_E   <= 1'b0;
            end
            S_NWAIT: if (w_done) begin
               if (r_step == 2'd3) begin
                  r_step  <= 2'd0;
                  r_byte  <= w_cfg0;
                  r_rs    <= 1'b0;
                  LCD_RS  <= 1'b0;
                  SF_DATA <= w_cfg0[7:4];
                  r_state <= S_SETUP_H;
               end else begin
                  r_step  <= w_step_nx;
                  SF_DATA <= (r_step == 2'd2) ? 4'h2 : 4'h3;
                  r_state <= S_NSETUP;
               end
            end
            S_SETUP_H: if (w_done) begin
               r_state <= S_PULSE_H;
               LCD_E   <= 1'b1;
            end
            S_PULSE_H: if (w_done) begin
               r_state <= S_GAP;
               LCD_E   <= 1'b0;
            end
            S_GAP: if (w_done) begin
               r_state <= S_SETUP_L;
               SF_DATA <= r_byte[3:0];
            end
            S_SETUP_L: if (w_done) begin
               r_state <= S_PULSE_L;
               LCD_E   <= 1'b1;
            end
            S_PULSE_L: if (w_done) begin
               r_state <= S_BWAIT;
               LCD_E   <= 1'b0;
            end
            S_BWAIT: if (w_done) begin
               if (!oInitDone && r_step != 2'd3) begin
                  r_step  <= w_step_nx;
                  r_byte  <= w_cfg_nx;
                  SF_DATA <= w_cfg_nx[7:4];
                  r_state <= S_SETUP_H;
               end else begin
                  r_state   <= S_IDLE;
                  r_ready   <= 1'b1;
                  oInitDone <= 1'b1;
               end
            end
            S_IDLE: if (host.iValid) begin
               r_byte  <= host.iData;
               r_rs    <= host.iRS;
               LCD_RS  <= host.iRS;
               SF_DATA <= host.iData[7:4];
               r_ready <= 1'b0;
               r_state <= S_SETUP_H;
            end
            default: r_state <= S_PWR;
         endcase
      end
   end

endmodule
